// File: rtl/snake_ladder_engine_if.sv
// Bus bundle for snake_ladder_engine: control inputs from the die logic, the
// match tracker and the configuration port, plus the board/status outputs to
// the screen and I2C drivers. Clock and reset stay outside the bundle.
interface snake_ladder_engine_if #(
    parameter int NUM_PLAYERS = 4,
    parameter int POS_W       = 6,
    parameter int NUM_JUMPS   = 8
);
    localparam int PIDX_W = $clog2(NUM_PLAYERS);
    localparam int JIDX_W = $clog2(NUM_JUMPS);

    logic                         start;
    logic                         restart;
    logic                         play_en;
    logic                         die_en;
    logic [2:0]                   die_value;
    logic                         final_state;
    logic                         next_match;
    logic                         exact_finish;
    logic                         cfg_wr;
    logic [JIDX_W-1:0]            cfg_idx;
    logic [POS_W-1:0]             cfg_from;
    logic [POS_W-1:0]             cfg_to;
    logic                         cfg_valid;

    logic [NUM_PLAYERS*POS_W-1:0] positions;
    logic [PIDX_W-1:0]            turn;
    logic                         wait_roll;
    logic                         jump_up;
    logic                         jump_down;
    logic [PIDX_W-1:0]            jump_player;
    logic [PIDX_W-1:0]            leader;
    logic                         tie;
    logic                         show_pulse;
    logic                         game_end;

    // Driver side (die logic, tracker, configuration host, testbench)
    modport master (
        output start, restart, play_en, die_en, die_value, final_state,
               next_match, exact_finish, cfg_wr, cfg_idx, cfg_from, cfg_to,
               cfg_valid,
        input  positions, turn, wait_roll, jump_up, jump_down, jump_player,
               leader, tie, show_pulse, game_end
    );

    // Engine side
    modport slave (
        input  start, restart, play_en, die_en, die_value, final_state,
               next_match, exact_finish, cfg_wr, cfg_idx, cfg_from, cfg_to,
               cfg_valid,
        output positions, turn, wait_roll, jump_up, jump_down, jump_player,
               leader, tie, show_pulse, game_end
    );
endinterface

// File: rtl/snake_ladder_engine.sv
// snake_ladder_engine: round-robin multi-player board engine with a
// runtime-programmable ladder/snake jump table.
// Optional feature macro: SNAKE_LADDER_EXTRA_TURN_EN (a six grants a bonus
// roll, at most two bonus rolls in a row per player).
//
//  state        | meaning
//  -------------+-------------------------------------------------------
//  IDLE         | powered up, waiting for start
//  NEW_MATCH    | reset turn, latch finish mode
//  WAIT_ROLL    | waiting for a valid die roll from player `turn`
//  MOVE_WAIT    | raw landing shown, counting down before jump lookup
//  ROUND_GAP    | round finished, ranking done, waiting before strobe
//  SHOW         | show_pulse cycle
//  CHECK_END    | finish detection
//  END_MATCH    | match over, waiting for the tracker
//  WAIT_RESTART | series over, waiting for restart
module snake_ladder_engine #(
    parameter int NUM_PLAYERS = 4,
    parameter int BOARD_MAX   = 40,
    parameter int POS_W       = 6,
    parameter int NUM_JUMPS   = 8,
    parameter int MOVE_DELAY  = 60_000_000,
    parameter int SHOW_GAP    = 300_000
) (
    input logic                  clk,
    input logic                  rst,
    snake_ladder_engine_if.slave bus
);
    localparam int PIDX_W = $clog2(NUM_PLAYERS);

    localparam logic [POS_W-1:0]  BMAX_P    = POS_W'(BOARD_MAX);
    localparam logic [POS_W:0]    BMAX_W    = (POS_W+1)'(BOARD_MAX);
    localparam logic [PIDX_W-1:0] LAST_P    = PIDX_W'(NUM_PLAYERS - 1);
    localparam logic [31:0]       MOVE_LOAD = 32'(MOVE_DELAY - 1);
    localparam logic [31:0]       SHOW_LOAD = 32'(SHOW_GAP - 1);

    typedef enum logic [3:0] {
        IDLE,
        NEW_MATCH,
        WAIT_ROLL,
        MOVE_WAIT,
        ROUND_GAP,
        SHOW,
        CHECK_END,
        END_MATCH,
        WAIT_RESTART
    } state_t;

    state_t            state;
    logic [POS_W-1:0]  pos [NUM_PLAYERS];
    logic [PIDX_W-1:0] turn_q;
    logic              exact_q;
    logic [31:0]       cnt;
    logic              wait_roll_q;
    logic              jump_up_q;
    logic              jump_down_q;
    logic [PIDX_W-1:0] jump_player_q;
    logic [PIDX_W-1:0] leader_q;
    logic              tie_q;
    logic              show_q;
    logic              game_end_q;

    logic [POS_W-1:0]  tbl_from  [NUM_JUMPS];
    logic [POS_W-1:0]  tbl_to    [NUM_JUMPS];
    logic              tbl_valid [NUM_JUMPS];

    logic [POS_W-1:0]  cur_pos;
    logic [POS_W:0]    sum;
    logic [POS_W-1:0]  bounce;
    logic [POS_W-1:0]  land;
    logic              roll_ok;
    logic              cfg_open;
    logic              hit;
    logic              hit_up;
    logic [POS_W-1:0]  hit_to;
    logic [POS_W-1:0]  max_v;
    logic [PIDX_W-1:0] lead_c;
    logic [3:0]        n_max;
    logic              tie_c;
    logic              any_finish;
    logic              keep_turn;

`ifdef SNAKE_LADDER_EXTRA_TURN_EN
    logic [1:0]        bonus_q;
    logic              six_q;
    assign keep_turn = six_q && (bonus_q != 2'd2);
`else
    assign keep_turn = 1'b0;
`endif

    // Power-on ladder/snake layout
    function automatic logic [POS_W-1:0] dflt_from(input int i);
        int v;
        case (i)
            0:       v = 3;
            1:       v = 8;
            2:       v = 23;
            3:       v = 11;
            4:       v = 35;
            5:       v = 26;
            default: v = 0;
        endcase
        return POS_W'(v);
    endfunction

    function automatic logic [POS_W-1:0] dflt_to(input int i);
        int v;
        case (i)
            0:       v = 10;
            1:       v = 17;
            2:       v = 30;
            3:       v = 0;
            4:       v = 32;
            5:       v = 14;
            default: v = 0;
        endcase
        return POS_W'(v);
    endfunction

    // Landing square for the current player: clamp or bounce at the last square
    assign cur_pos = pos[turn_q];
    assign sum     = {1'b0, cur_pos} + {{(POS_W-2){1'b0}}, bus.die_value};
    assign bounce  = POS_W'({BMAX_W, 1'b0} - {1'b0, sum});
    assign land    = (sum > BMAX_W) ? (exact_q ? bounce : BMAX_P) : sum[POS_W-1:0];
    assign roll_ok = bus.die_en && (bus.die_value != 3'd0) && (bus.die_value != 3'd7);

    assign cfg_open = (state == IDLE) || (state == END_MATCH) || (state == WAIT_RESTART);

    // Jump lookup: scan from the top so the lowest matching index wins
    always_comb begin
        hit    = 1'b0;
        hit_up = 1'b0;
        hit_to = '0;
        for (int i = NUM_JUMPS - 1; i >= 0; i--) begin
            if (tbl_valid[i] && (tbl_from[i] != '0) && (tbl_from[i] < BMAX_P) &&
                (tbl_to[i] <= BMAX_P) && (tbl_from[i] == cur_pos)) begin
                hit    = 1'b1;
                hit_to = tbl_to[i];
                hit_up = tbl_to[i] > tbl_from[i];
            end
        end
    end

    // Ranking and finish detection across all players
    always_comb begin
        max_v      = pos[0];
        lead_c     = '0;
        n_max      = '0;
        any_finish = 1'b0;
        for (int i = 1; i < NUM_PLAYERS; i++) begin
            if (pos[i] > max_v) begin
                max_v  = pos[i];
                lead_c = PIDX_W'(i);
            end
        end
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (pos[i] == max_v) n_max = n_max + 4'd1;
            if (pos[i] == BMAX_P) any_finish = 1'b1;
        end
        tie_c = n_max > 4'd1;
    end

    // Jump table register file; writes only land while no turn is in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_JUMPS; i++) begin
                tbl_from[i]  <= dflt_from(i);
                tbl_to[i]    <= dflt_to(i);
                tbl_valid[i] <= (i < 6);
            end
        end else if (bus.cfg_wr && cfg_open) begin
            tbl_from[bus.cfg_idx]  <= bus.cfg_from;
            tbl_to[bus.cfg_idx]    <= bus.cfg_to;
            tbl_valid[bus.cfg_idx] <= bus.cfg_valid;
        end
    end

    // Game sequencer with registered outputs; play_en=0 freezes the play states
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            for (int i = 0; i < NUM_PLAYERS; i++) pos[i] <= '0;
            turn_q        <= '0;
            exact_q       <= 1'b0;
            cnt           <= '0;
            wait_roll_q   <= 1'b0;
            jump_up_q     <= 1'b0;
            jump_down_q   <= 1'b0;
            jump_player_q <= '0;
            leader_q      <= '0;
            tie_q         <= 1'b0;
            show_q        <= 1'b0;
            game_end_q    <= 1'b0;
`ifdef SNAKE_LADDER_EXTRA_TURN_EN
            bonus_q       <= '0;
            six_q         <= 1'b0;
`endif
        end else begin
            jump_up_q   <= 1'b0;
            jump_down_q <= 1'b0;
            show_q      <= 1'b0;
            game_end_q  <= 1'b0;
            if (bus.play_en || (state == IDLE) || (state == WAIT_RESTART)) begin
                case (state)
                    IDLE: begin
                        if (bus.start) begin
                            for (int i = 0; i < NUM_PLAYERS; i++) pos[i] <= '0;
                            state <= NEW_MATCH;
                        end
                    end
                    NEW_MATCH: begin
                        turn_q      <= '0;
                        exact_q     <= bus.exact_finish;
                        wait_roll_q <= 1'b1;
                        state       <= WAIT_ROLL;
`ifdef SNAKE_LADDER_EXTRA_TURN_EN
                        bonus_q     <= '0;
`endif
                    end
                    WAIT_ROLL: begin
                        if (roll_ok) begin
                            pos[turn_q] <= land;
                            wait_roll_q <= 1'b0;
                            cnt         <= MOVE_LOAD;
                            state       <= MOVE_WAIT;
`ifdef SNAKE_LADDER_EXTRA_TURN_EN
                            six_q       <= (bus.die_value == 3'd6);
`endif
                        end
                    end
                    MOVE_WAIT: begin
                        if (cnt == '0) begin
                            if (hit) begin
                                pos[turn_q]   <= hit_to;
                                jump_up_q     <= hit_up;
                                jump_down_q   <= !hit_up;
                                jump_player_q <= turn_q;
                            end
`ifdef SNAKE_LADDER_EXTRA_TURN_EN
                            bonus_q <= keep_turn ? bonus_q + 2'd1 : 2'd0;
`endif
                            if (keep_turn) begin
                                wait_roll_q <= 1'b1;
                                state       <= WAIT_ROLL;
                            end else if (turn_q != LAST_P) begin
                                turn_q      <= turn_q + 1'b1;
                                wait_roll_q <= 1'b1;
                                state       <= WAIT_ROLL;
                            end else begin
                                cnt   <= SHOW_LOAD;
                                state <= ROUND_GAP;
                            end
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    ROUND_GAP: begin
                        leader_q <= lead_c;
                        tie_q    <= tie_c;
                        if (cnt == '0) begin
                            show_q <= 1'b1;
                            state  <= SHOW;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    SHOW: begin
                        state <= CHECK_END;
                    end
                    CHECK_END: begin
                        if (any_finish) begin
                            game_end_q <= 1'b1;
                            state      <= END_MATCH;
                        end else begin
                            turn_q      <= '0;
                            wait_roll_q <= 1'b1;
                            state       <= WAIT_ROLL;
                        end
                    end
                    END_MATCH: begin
                        if (bus.final_state) begin
                            state <= WAIT_RESTART;
                        end else if (bus.next_match) begin
                            for (int i = 0; i < NUM_PLAYERS; i++) pos[i] <= '0;
                            state <= NEW_MATCH;
                        end
                    end
                    WAIT_RESTART: begin
                        if (bus.restart) state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_pack
        assign bus.positions[g*POS_W +: POS_W] = pos[g];
    end

    assign bus.turn        = turn_q;
    assign bus.wait_roll   = wait_roll_q;
    assign bus.jump_up     = jump_up_q;
    assign bus.jump_down   = jump_down_q;
    assign bus.jump_player = jump_player_q;
    assign bus.leader      = leader_q;
    assign bus.tie         = tie_q;
    assign bus.show_pulse  = show_q;
    assign bus.game_end    = game_end_q;
endmodule

// File: tb/tb_snake_ladder_engine.sv
// Self-checking bench for snake_ladder_engine: three players, short timers,
// reference model of board, jump table and turn order, scoreboard of moves.
module tb_snake_ladder_engine;
    localparam int NP   = 3;
    localparam int PW   = 6;
    localparam int NJ   = 8;
    localparam int BMAX = 40;
    localparam int MD   = 4;
    localparam int SG   = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    snake_ladder_engine_if #(.NUM_PLAYERS(NP), .POS_W(PW), .NUM_JUMPS(NJ)) bus ();

    snake_ladder_engine #(
        .NUM_PLAYERS(NP), .BOARD_MAX(BMAX), .POS_W(PW), .NUM_JUMPS(NJ),
        .MOVE_DELAY(MD), .SHOW_GAP(SG)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        int player;
        int raw;
        int fin;
        int up;
        int dn;
    } exp_t;

    exp_t sb[$];

    int n_vec  = 0;
    int n_miss = 0;

    int m_pos[NP];
    int m_turn, m_bonus, m_jp;
    bit m_exact, m_round_done, m_ended;
    int t_from[NJ];
    int t_to[NJ];
    bit t_val[NJ];

    int rolls[27] = '{2,5,1, 1,6,2, 2,1,6, 1,1,6, 1,2,6, 1,1,6, 1,1,3, 1,1,6, 1,1,3};

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int get_pos(input int p);
        return int'(bus.positions[p*PW +: PW]);
    endfunction

    function automatic int model_land(input int p, input int v);
        int s;
        s = p + v;
        if (s > BMAX) return m_exact ? (2 * BMAX - s) : BMAX;
        return s;
    endfunction

    task automatic do_roll(input int v, input int hold);
        exp_t e;
        bit   hit;
        bit   keep;
        chk("pre_wait_roll", bus.wait_roll, 1);
        chk("pre_turn", bus.turn, m_turn);
        e.player = m_turn;
        e.raw    = model_land(m_pos[m_turn], v);
        e.fin    = e.raw;
        e.up     = 0;
        e.dn     = 0;
        hit      = 0;
        for (int i = 0; i < NJ; i++) begin
            if (!hit && t_val[i] && t_from[i] != 0 && t_from[i] < BMAX &&
                t_to[i] <= BMAX && t_from[i] == e.raw) begin
                hit   = 1;
                e.fin = t_to[i];
                e.up  = (t_to[i] > t_from[i]) ? 1 : 0;
                e.dn  = 1 - e.up;
            end
        end
        sb.push_back(e);
        m_pos[m_turn] = e.fin;
        if (hit) m_jp = m_turn;
        keep = 0;
`ifdef SNAKE_LADDER_EXTRA_TURN_EN
        keep    = (v == 6) && (m_bonus < 2);
        m_bonus = keep ? m_bonus + 1 : 0;
`endif
        m_round_done = 0;
        if (!keep) begin
            if (m_turn < NP - 1) m_turn++;
            else m_round_done = 1;
        end

        bus.die_en    = 1'b1;
        bus.die_value = 3'(v);
        @(negedge clk);
        bus.die_en = 1'b0;
        e = sb.pop_front();
        chk("raw_pos", get_pos(e.player), e.raw);
        chk("wait_roll_drop", bus.wait_roll, 0);
        if (hold > 0) begin
            bus.play_en   = 1'b0;
            bus.die_en    = 1'b1;
            bus.die_value = 3'd3;
            repeat (hold) @(negedge clk);
            bus.play_en = 1'b1;
            bus.die_en  = 1'b0;
        end
        repeat (MD - 1) @(negedge clk);
        chk("pre_jump_pos", get_pos(e.player), e.raw);
        chk("early_jump", bus.jump_up | bus.jump_down, 0);
        @(negedge clk);
        chk("final_pos", get_pos(e.player), e.fin);
        chk("jump_up", bus.jump_up, e.up);
        chk("jump_down", bus.jump_down, e.dn);
        chk("jump_player", bus.jump_player, m_jp);
        chk("turn_after", bus.turn, m_turn);
        chk("wait_roll_after", bus.wait_roll, m_round_done ? 0 : 1);
    endtask

    task automatic end_of_round();
        int cyc;
        int ml;
        int nm;
        bit fin;
        ml = 0;
        nm = 0;
        fin = 0;
        for (int i = 1; i < NP; i++) if (m_pos[i] > m_pos[ml]) ml = i;
        for (int i = 0; i < NP; i++) begin
            if (m_pos[i] == m_pos[ml]) nm++;
            if (m_pos[i] == BMAX) fin = 1;
        end
        cyc = 0;
        while (bus.show_pulse !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("show_delay", cyc, SG);
        chk("leader", bus.leader, ml);
        chk("tie", bus.tie, (nm > 1) ? 1 : 0);
        @(negedge clk);
        chk("show_width", bus.show_pulse, 0);
        @(negedge clk);
        chk("game_end", bus.game_end, fin);
        if (fin) begin
            m_ended = 1;
            @(negedge clk);
            chk("game_end_width", bus.game_end, 0);
        end else begin
            m_turn = 0;
            chk("new_round_wait", bus.wait_roll, 1);
            chk("new_round_turn", bus.turn, 0);
        end
        m_round_done = 0;
    endtask

    task automatic start_match(input bit via_next, input bit exact);
        bus.exact_finish = exact;
        if (via_next) bus.next_match = 1'b1;
        else bus.start = 1'b1;
        @(negedge clk);
        bus.start      = 1'b0;
        bus.next_match = 1'b0;
        @(negedge clk);
        bus.exact_finish = !exact;
        for (int i = 0; i < NP; i++) m_pos[i] = 0;
        m_turn = 0; m_bonus = 0; m_exact = exact; m_ended = 0; m_round_done = 0;
        chk("match_wait_roll", bus.wait_roll, 1);
        chk("match_turn", bus.turn, 0);
        for (int i = 0; i < NP; i++) chk("match_pos", get_pos(i), 0);
    endtask

    task automatic play_match(input int hold_idx);
        for (int i = 0; i < 27 && !m_ended; i++) begin
            do_roll(rolls[i], (i == hold_idx) ? 3 : 0);
            if (m_round_done) end_of_round();
        end
    endtask

    task automatic roll_close(input int v);
        do_roll(v, 0);
        if (m_round_done) end_of_round();
    endtask

    task automatic cfg_write(input int idx, input int from, input int to, input bit val);
        bus.cfg_wr    = 1'b1;
        bus.cfg_idx   = 3'(idx);
        bus.cfg_from  = 6'(from);
        bus.cfg_to    = 6'(to);
        bus.cfg_valid = val;
        @(negedge clk);
        bus.cfg_wr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        bus.start = 0; bus.restart = 0; bus.play_en = 1; bus.die_en = 0;
        bus.die_value = 0; bus.final_state = 0; bus.next_match = 0;
        bus.exact_finish = 0; bus.cfg_wr = 0; bus.cfg_idx = 0; bus.cfg_from = 0;
        bus.cfg_to = 0; bus.cfg_valid = 0;
        t_from = '{3, 8, 23, 11, 35, 26, 0, 0};
        t_to   = '{10, 17, 30, 0, 32, 14, 0, 0};
        t_val  = '{1, 1, 1, 1, 1, 1, 0, 0};
        m_jp = 0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < NP; i++) chk("rst_pos", get_pos(i), 0);
        chk("rst_turn", bus.turn, 0);
        chk("rst_wait_roll", bus.wait_roll, 0);
        chk("rst_leader", bus.leader, 0);
        chk("rst_tie", bus.tie, 0);
        chk("rst_jump_player", bus.jump_player, 0);
        chk("rst_pulses", {bus.jump_up, bus.jump_down, bus.show_pulse, bus.game_end}, 0);
        rst = 1'b0;
        @(negedge clk);

        // Match 1: clamp mode, config write during play must be dropped
        start_match(0, 0);
        cfg_write(6, 5, 39, 1);
        bus.die_en = 1'b1; bus.die_value = 3'd7;
        @(negedge clk);
        bus.die_value = 3'd0;
        @(negedge clk);
        bus.die_en = 1'b0;
        chk("bad_roll_wait", bus.wait_roll, 1);
        chk("bad_roll_pos", get_pos(0), 0);
        play_match(4);

        // Match 2 via tracker, bounce mode
        start_match(1, 1);
        play_match(-1);

        // Series over: final_state wins over next_match
        bus.final_state = 1'b1; bus.next_match = 1'b1;
        @(negedge clk);
        bus.final_state = 1'b0; bus.next_match = 1'b0;
        @(negedge clk);
        bus.next_match = 1'b1;
        @(negedge clk);
        bus.next_match = 1'b0;
        repeat (2) @(negedge clk);
        chk("wr_wait_roll", bus.wait_roll, 0);
        for (int i = 0; i < NP; i++) chk("wr_pos_kept", get_pos(i), m_pos[i]);
        bus.restart = 1'b1;
        @(negedge clk);
        bus.restart = 1'b0;

        // Config write in IDLE takes effect
        cfg_write(6, 5, 39, 1);
        t_from[6] = 5; t_to[6] = 39; t_val[6] = 1;
        start_match(0, 0);
        roll_close(5);
        roll_close(3);
        roll_close(4);
`ifdef SNAKE_LADDER_EXTRA_TURN_EN
        roll_close(6);
        roll_close(6);
        roll_close(6);
        roll_close(1);
        roll_close(1);
`endif

        // Reset in the middle of play aborts at once
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NP; i++) chk("midrst_pos", get_pos(i), 0);
        chk("midrst_turn", bus.turn, 0);
        chk("midrst_wait_roll", bus.wait_roll, 0);
        chk("midrst_jump_player", bus.jump_player, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/snake_ladder_engine.md
Name: snake_ladder_engine

Overview:
- Parametrised successor to the two-player board FSM: runs 2..NUM_PLAYERS round-robin turns on a BOARD_MAX-square board.
- Each turn: accept a die roll, show the raw landing, wait MOVE_DELAY cycles, apply a runtime-programmable ladder/snake jump table, then advance.
- After each full round it ranks players, pulses the display/I2C strobe, and checks for a finish.
- Sits between the die logic, the match/victory tracker and the screen/I2C drivers.

Parameters:
- NUM_PLAYERS, 4, player count (2..8)
- BOARD_MAX, 40, final square (≤ 2^POS_W−1)
- POS_W, 6, position width
- NUM_JUMPS, 8, jump-table entries
- MOVE_DELAY, 60_000_000, cycles between raw landing and jump resolution
- SHOW_GAP, 300_000, cycles between round end and show_pulse
- PIDX_W, $clog2(NUM_PLAYERS), player index width
- JIDX_W, $clog2(NUM_JUMPS), table index width

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- start  in  1  pulse; leave IDLE
- restart  in  1  pulse; WAIT_RESTART→IDLE
- play_en  in  1  0 freezes play states
- die_en  in  1  roll-valid pulse
- die_value  in  3  roll 1..6
- final_state  in  1  tracker: series over (level)
- next_match  in  1  tracker: start next match (pulse)
- exact_finish  in  1  1 = bounce past BOARD_MAX, 0 = clamp; sampled at NEW_MATCH
- cfg_wr  in  1  jump-table write strobe
- cfg_idx  in  JIDX_W  entry index
- cfg_from  in  POS_W  trigger square
- cfg_to  in  POS_W  destination square
- cfg_valid  in  1  entry enable
- positions  out  NUM_PLAYERS*POS_W  packed, player 0 in LSBs
- turn  out  PIDX_W  player whose roll is awaited
- wait_roll  out  1  high in WAIT_ROLL
- jump_up  out  1  1-cycle pulse; ladder taken
- jump_down  out  1  1-cycle pulse; snake taken
- jump_player  out  PIDX_W  player for the jump pulse; holds until the next jump
- leader  out  PIDX_W  lowest-index player holding the max position
- tie  out  1  ≥2 players share the max
- show_pulse  out  1  1-cycle round-result strobe
- game_end  out  1  1-cycle finish pulse

Behaviour:
- Reset (clk edge, rst=1):
  - state IDLE; all positions, turn, leader, tie and jump_player 0; all pulses 0; wait_roll 0; counters 0.
  - Table: 0:3→10, 1:8→17, 2:23→30, 3:11→0, 4:35→32, 5:26→14, all valid; remaining entries invalid.
  - Reset mid-play aborts immediately.
- States: IDLE, NEW_MATCH, WAIT_ROLL, MOVE_WAIT, ROUND_GAP, SHOW, CHECK_END, END_MATCH, WAIT_RESTART.
- play_en=0:
  - Every state except IDLE and WAIT_RESTART holds.
  - Counters hold; die_en and next_match are ignored.
- IDLE: start → NEW_MATCH; positions cleared.
- NEW_MATCH: turn=0; latch exact_finish → WAIT_ROLL.
- WAIT_ROLL:
  - On die_en with die_value 1..6, compute s = pos[turn] + die_value, evaluated at POS_W+1 bits.
  - Clamp mode: min(s, BOARD_MAX).
  - Bounce mode: s > BOARD_MAX gives 2·BOARD_MAX − s.
  - Write the result, drop wait_roll, go to MOVE_WAIT.
  - die_value 0 or 7 is ignored; stay in WAIT_ROLL.
- MOVE_WAIT:
  - After exactly MOVE_DELAY cycles, look up pos[turn] in the table; the lowest-index valid entry with a matching cfg_from wins.
  - On a hit: pos ← to; pulse jump_up if to > from, else jump_down; jump_player ← turn.
  - Entries with from = 0, from ≥ BOARD_MAX, or to > BOARD_MAX never match.
  - If turn < NUM_PLAYERS−1: turn+1 → WAIT_ROLL. Otherwise → ROUND_GAP.
- ROUND_GAP:
  - leader and tie are updated on the entry cycle.
  - After SHOW_GAP cycles, show_pulse=1 → SHOW.
- SHOW: show_pulse back to 0 → CHECK_END.
- CHECK_END:
  - Any pos == BOARD_MAX: game_end=1 → END_MATCH.
  - Otherwise turn=0 → WAIT_ROLL.
- END_MATCH: final_state → WAIT_RESTART (final_state takes priority); else next_match → NEW_MATCH with positions cleared.
- WAIT_RESTART: restart → IDLE.
- Config writes:
  - cfg_wr is honoured only in IDLE, END_MATCH and WAIT_RESTART; otherwise dropped.
  - Writes take effect for the next lookup.
- Simultaneous events: die_en arriving in any state but WAIT_ROLL is dropped, not queued.
- Latencies: die_en to raw position is 1 cycle; the jump result lands MOVE_DELAY+1 cycles after die_en.

Optional Feature:
- Macro: SNAKE_LADDER_EXTRA_TURN_EN.
- Defined: a roll of 6 keeps the same turn. After MOVE_WAIT the FSM returns to WAIT_ROLL without incrementing turn, at most 2 consecutive bonus rolls per player; the third six passes the turn normally.
- Undefined: every roll passes the turn.

Test Plan:
- Setup for all scenarios: NUM_PLAYERS=3, MOVE_DELAY=4, SHOW_GAP=3, reset table.
- Basic round: start; rolls 2,5,1 → positions 2,5,1; show_pulse once, 3 cycles after the last MOVE_WAIT; leader=1, tie=0.
- Ladder: P0 at 0 rolls 3 → raw 3 one cycle after die_en; 10 plus jump_up, jump_player=0, exactly 5 cycles after die_en. Snake: P1 lands 11 → 0 with jump_down.
- Finish modes:
  - Clamp: P2 at 37 rolls 6 → 40; game_end after SHOW.
  - exact_finish=1: same roll → 37; no game_end.
- Tracker handshake: in END_MATCH, next_match → positions cleared, turn=0. Separately, final_state=1 and next_match=1 together → WAIT_RESTART; restart → IDLE.
- Config and freeze:
  - cfg_wr idx 6, 5→39, valid, during WAIT_ROLL → ignored; the same write in IDLE → landing on 5 yields 39.
  - play_en=0 mid-MOVE_WAIT holds the count; die_value 7 ignored.
- Extra turn (macro defined): rolls 6,6,6 by P0 → turn stays 0 twice, then advances to 1.
